inv_byte_sub_seq: RTL and testbench

INV_BYTE_SUB_SEQ -- requirements
Module: inv_byte_sub_seq

---
 rtl/inv_byte_sub_seq.sv | 140 ++++++++++++++
 tb/tb_inv_byte_sub_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_byte_sub_seq.sv
// Sequential AES inverse SubBytes: accepts a 128-bit state, pushes it through
// the FIPS-197 inverse S-box LANES bytes per cycle (most-significant word
// first), then holds the result under a valid/ready handshake.
module inv_byte_sub_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(LANES == 4 || LANES == 16)) begin : g_bad_lanes
        $error("inv_byte_sub_seq: LANES must be 4 or 16");
    end

    localparam int         NW       = 16 / LANES;   // words per block
    localparam int         LW       = LANES * 8;    // word width in bits
    localparam logic [1:0] LAST_CNT = 2'(NW - 1);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [127:0]   r_work,  w_work_nxt;
    logic [1:0]     r_cnt,   w_cnt_nxt;
    logic           r_out_valid, w_out_valid_nxt;
    logic [6:0]     w_base;
    logic [LW-1:0]  w_sel;
    logic [LW-1:0]  w_sub;

    // Word currently being substituted; word 0 sits at the top of the state.
    assign w_base = 7'((NW - 1 - int'(r_cnt)) * LW);
    assign w_sel  = r_work[w_base +: LW];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_sub[g*8 +: 8] = INV_SBOX[w_sel[g*8 +: 8]];
    end

    assign out_data  = r_work;
    assign out_valid = r_out_valid;

    // State and datapath registers; everything clears on reset so outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the working register is reset too, because out_data is
            // sourced from it and must read zero (not X) straight out of reset.
            r_state     <= IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state     <= w_state_nxt;
            r_work      <= w_work_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and infers a latch.
        w_state_nxt     = r_state;
        w_work_nxt      = r_work;
        w_cnt_nxt       = r_cnt;
        w_out_valid_nxt = r_out_valid;
        in_ready        = 1'b0;
        busy            = 1'b0;

        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_work_nxt  = in_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SUB;
                end
            end
            SUB: begin
                busy                       = 1'b1;
                w_work_nxt[w_base +: LW]   = w_sub;
                if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt       = '0;
                    w_state_nxt     = HOLD;
                    w_out_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (in_valid) begin
                        w_work_nxt  = in_data;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SUB;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_inv_byte_sub_seq.sv
// Directed bench for inv_byte_sub_seq: known vectors, S-box round trip,
// output stall, mid-block reset and back-to-back streaming, on LANES=4 and 16.
module tb_inv_byte_sub_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic         out_ready;
    logic         v4, r4, ov4, busy4;
    logic         v16, r16, ov16, busy16;
    logic [127:0] od4, od16;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    inv_byte_sub_seq #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(r4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .busy(busy4)
    );

    inv_byte_sub_seq #(.LANES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v16), .in_ready(r16), .in_data(in_data),
        .out_valid(ov16), .out_ready(out_ready), .out_data(od16),
        .busy(busy16)
    );

    // Forward FIPS-197 S-box, used to build round-trip stimulus.
    logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called just after a rising edge; presents one block and completes the accept edge.
    task automatic start(input bit wide, input logic [127:0] d);
        in_data = d;
        if (wide) v16 = 1'b1; else v4 = 1'b1;
        #1;
        check("accept_ready", 128'(wide ? r16 : r4), 128'(1));
        @(posedge clk); #1;
        v4  = 1'b0;
        v16 = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; lat=-1 if the bound expires.
    task automatic collect(input bit wide, output logic [127:0] q, output int lat);
        lat = -1;
        q   = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (wide ? ov16 : ov4) begin
                lat = k;
                q   = wide ? od16 : od4;
                break;
            end
        end
    endtask

    initial begin
        logic [127:0] q, d, e, held;
        int lat;
        int sent, got;
        int acc_q[$];
        bit acc;

        vecs.push_back('{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb});
        vecs.push_back('{{16{8'h63}}, {16{8'h00}}});
        vecs.push_back('{{16{8'h16}}, {16{8'hff}}});
        vecs.push_back('{{16{8'h7c}}, {16{8'h01}}});
        vecs.push_back('{{16{8'h00}}, {16{8'h52}}});

        rst_n = 1'b0; v4 = 1'b0; v16 = 1'b0; out_ready = 1'b1; in_data = '0;
        @(posedge clk); #1;
        check("rst_ov4",    128'(ov4),    128'(0));
        check("rst_od4",    od4,          128'(0));
        check("rst_ready4", 128'(r4),     128'(1));
        check("rst_busy4",  128'(busy4),  128'(0));
        check("rst_ov16",   128'(ov16),   128'(0));
        check("rst_od16",   od16,         128'(0));
        check("rst_ready16",128'(r16),    128'(1));
        check("rst_busy16", 128'(busy16), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors on both widths; result must last exactly one cycle.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                start(w[0], vecs[i].din);
                check("busy_in_sub", 128'(w[0] ? busy16 : busy4), 128'(1));
                collect(w[0], q, lat);
                check("latency", 128'(lat), 128'(w[0] ? 1 : 4));
                check("kat_data", q, vecs[i].exp);
                @(posedge clk); #1;
                check("valid_one_cycle", 128'(w[0] ? ov16 : ov4), 128'(0));
            end
        end

        // Round trip: every byte value through S then InvS, in every lane position.
        for (int w = 0; w < 2; w++) begin
            for (int j = 0; j < 256; j++) begin
                d = '0;
                e = '0;
                for (int i = 0; i < 16; i++) begin
                    d = {d[119:0], SBOX[8'(j + i)]};
                    e = {e[119:0], 8'(j + i)};
                end
                start(w[0], d);
                collect(w[0], q, lat);
                check("round_trip", q, e);
            end
            @(posedge clk); #1;
        end

        // Output stall for 10 cycles, then simultaneous output/input handshake.
        out_ready = 1'b0;
        start(1'b0, vecs[0].din);
        collect(1'b0, held, lat);
        check("stall_latency", 128'(lat), 128'(4));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("stall_valid", 128'(ov4), 128'(1));
            check("stall_data",  od4,       held);
            check("stall_ready", 128'(r4),  128'(0));
        end
        in_data   = vecs[2].din;
        v4        = 1'b1;
        out_ready = 1'b1;
        #1;
        check("hold_ready", 128'(r4), 128'(1));
        @(posedge clk); #1;
        v4 = 1'b0;
        check("hold_reload_valid", 128'(ov4),   128'(0));
        check("hold_reload_busy",  128'(busy4), 128'(1));
        collect(1'b0, q, lat);
        check("reload_latency", 128'(lat), 128'(4));
        check("reload_data",    q,         vecs[2].exp);
        @(posedge clk); #1;

        // Reset while SUB is on word 2: block abandoned, outputs zero immediately.
        start(1'b0, vecs[1].din);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ov",    128'(ov4),   128'(0));
        check("midrst_od",    od4,         128'(0));
        check("midrst_busy",  128'(busy4), 128'(0));
        check("midrst_ready", 128'(r4),    128'(1));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", 128'(ov4), 128'(0));
        end
        rst_n = 1'b1;
        start(1'b0, vecs[3].din);
        collect(1'b0, q, lat);
        check("postrst_latency", 128'(lat), 128'(4));
        check("postrst_data",    q,         vecs[3].exp);
        @(posedge clk); #1;

        // Back-to-back stream with in_valid held high: each result 4 edges after its accept, in order.
        sent = 0;
        got  = 0;
        in_data = vecs[0].din;
        v4 = 1'b1;
        for (int cyc = 1; cyc <= 100 && got < 6; cyc++) begin
            acc = v4 && r4;
            @(posedge clk); #1;
            if (acc) begin
                acc_q.push_back(cyc);
                sent++;
                if (sent < 6) in_data = vecs[sent % vecs.size()].din;
                else v4 = 1'b0;
            end
            if (ov4) begin
                if (acc_q.size() == 0) begin
                    check("stream_spurious", 128'(1), 128'(0));
                end else begin
                    check("stream_data", od4, vecs[got % vecs.size()].exp);
                    check("stream_latency", 128'(cyc - acc_q.pop_front()), 128'(4));
                end
                got++;
            end
        end
        v4 = 1'b0;
        check("stream_count", 128'(got), 128'(6));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
